// File: rtl/dvi_stream_tx.sv
// DVI transmit front-end: programmable raster timing, latency-matched control delay line,
// test-pattern colour mux and three TMDS 8b/10b encoders in the pixel clock domain.
module dvi_stream_tx #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned PIX_LAT   = 1,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW       = $clog2(H_TOTAL),
  localparam int unsigned YW       = $clog2(V_TOTAL)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           mode_i,
  input  logic [3*COLOR_W-1:0] solid_i,
  input  logic [COLOR_W-1:0]   red_i,
  input  logic [COLOR_W-1:0]   green_i,
  input  logic [COLOR_W-1:0]   blue_i,
  output logic [XW-1:0]        x_o,
  output logic [YW-1:0]        y_o,
  output logic                 frame_start_o,
  output logic [9:0]           tmds_blue_o,
  output logic [9:0]           tmds_green_o,
  output logic [9:0]           tmds_red_o,
  output logic                 vsync_o
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic [XW-1:0] x;
  } ctl_t;

  typedef struct packed {
    logic [9:0] sym;
    logic [5:0] cnt;
  } enc_t;

  localparam ctl_t CTL_RST = '{de: 1'b0, hs: ~HSYNC_POL, vs: ~VSYNC_POL, x: '0};

  // Raster counters
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   x_ext, y_ext;

  assign x_ext = 32'(x_q);
  assign y_ext = 32'(y_q);

  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_ext == H_TOTAL - 1) begin
      x_d = '0;
      y_d = (y_ext == V_TOTAL - 1) ? '0 : y_q + YW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = rst_ni && (x_q == '0) && (y_q == '0);

  // Mode and solid colour only change on frame boundaries so a frame never tears
  logic [1:0]           mode_q;
  logic [3*COLOR_W-1:0] solid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q  <= '0;
      solid_q <= '0;
    end else if (frame_start_o) begin
      mode_q  <= mode_i;
      solid_q <= solid_i;
    end
  end

  // Without a delay line the first pixel is muxed in the latching cycle itself
  logic [1:0]           mode_use;
  logic [3*COLOR_W-1:0] solid_use;

  assign mode_use  = (PIX_LAT == 0 && frame_start_o) ? mode_i  : mode_q;
  assign solid_use = (PIX_LAT == 0 && frame_start_o) ? solid_i : solid_q;

  // Control signals at the counter stage, syncs already at line level
  ctl_t ctl_cur, ctl_dly;

  always_comb begin
    ctl_cur.de = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
    ctl_cur.hs = (x_ext >= HS_START && x_ext < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    ctl_cur.vs = (y_ext >= VS_START && y_ext < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    ctl_cur.x  = x_q;
  end

  if (PIX_LAT == 0) begin : g_no_dly
    assign ctl_dly = ctl_cur;
  end else begin : g_dly
    ctl_t pipe_q [PIX_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= CTL_RST;
      end else begin
        pipe_q[0] <= ctl_cur;
        for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign ctl_dly = pipe_q[PIX_LAT-1];
  end

  // Colour selection at the delayed stage
  logic [31:0]        bar_q32;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  assign bar_q32 = 32'(ctl_dly.x) / BAR_W;
  assign bar_idx = (bar_q32 >= 7) ? 3'd7 : 3'(bar_q32);

  always_comb begin
    pix_r = red_i;
    pix_g = green_i;
    pix_b = blue_i;
    case (mode_use)
      2'd1: begin
        // White, yellow, cyan, green, magenta, red, blue, black
        pix_r = {COLOR_W{~bar_idx[1]}};
        pix_g = {COLOR_W{~bar_idx[2]}};
        pix_b = {COLOR_W{~bar_idx[0]}};
      end
      2'd2: begin
        pix_r = solid_use[3*COLOR_W-1 -: COLOR_W];
        pix_g = solid_use[2*COLOR_W-1 -: COLOR_W];
        pix_b = solid_use[COLOR_W-1 -: COLOR_W];
      end
      default: ;
    endcase
  end

  // DVI 1.0 encoder; cnt is the signed running disparity carried between pixels
  function automatic enc_t tmds_encode(input logic [7:0] d, input logic de,
                                       input logic [1:0] c, input logic [5:0] cnt_in);
    enc_t       r;
    logic [8:0] qm;
    logic       use_xnor;
    int         n1d, n1q, n0q, cnt;
    r.sym = CTL_00;
    r.cnt = '0;
    if (!de) begin
      unique case (c)
        2'b00: r.sym = CTL_00;
        2'b01: r.sym = CTL_01;
        2'b10: r.sym = CTL_10;
        2'b11: r.sym = CTL_11;
      endcase
    end else begin
      n1d      = $countones(d);
      use_xnor = (n1d > 4) || (n1d == 4 && !d[0]);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~use_xnor;
      n1q   = $countones(qm[7:0]);
      n0q   = 8 - n1q;
      cnt   = int'($signed(cnt_in));
      if (cnt == 0 || n1q == n0q) begin
        r.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt   = qm[8] ? cnt + n1q - n0q : cnt + n0q - n1q;
      end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
        r.sym = {1'b1, qm[8], ~qm[7:0]};
        cnt   = cnt + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
        r.sym = {1'b0, qm[8], qm[7:0]};
        cnt   = cnt - (qm[8] ? 0 : 2) + n1q - n0q;
      end
      r.cnt = 6'(cnt);
    end
    return r;
  endfunction

  logic [5:0] cnt_r_q, cnt_g_q, cnt_b_q;
  enc_t       enc_r, enc_g, enc_b;

  always_comb begin
    enc_r = tmds_encode(pix_r, ctl_dly.de, 2'b00, cnt_r_q);
    enc_g = tmds_encode(pix_g, ctl_dly.de, 2'b00, cnt_g_q);
    enc_b = tmds_encode(pix_b, ctl_dly.de, {ctl_dly.vs, ctl_dly.hs}, cnt_b_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmds_red_o   <= CTL_00;
      tmds_green_o <= CTL_00;
      tmds_blue_o  <= CTL_00;
      cnt_r_q      <= '0;
      cnt_g_q      <= '0;
      cnt_b_q      <= '0;
      vsync_o      <= ~VSYNC_POL;
    end else begin
      tmds_red_o   <= enc_r.sym;
      tmds_green_o <= enc_g.sym;
      tmds_blue_o  <= enc_b.sym;
      cnt_r_q      <= enc_r.cnt;
      cnt_g_q      <= enc_g.cnt;
      cnt_b_q      <= enc_b.cnt;
      vsync_o      <= ctl_dly.vs;
    end
  end

endmodule

// File: tb/tb_dvi_stream_tx.sv
// Directed bench for dvi_stream_tx on a reduced 24x8 raster: dut_a (PIX_LAT=1, active-low
// syncs) exercises patterns and sync timing, dut_b (PIX_LAT=3, active-high syncs) external data.
module tb_dvi_stream_tx;

  localparam int HT = 24;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] ZERO_A = 10'b0100000000;
  localparam logic [9:0] ZERO_B = 10'b1111111111;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] solid_a, solid_b;
  logic [7:0]  red_a, grn_a, blu_a, red_b, grn_b, blu_b;
  logic [4:0]  x_a, x_b;
  logic [2:0]  y_a, y_b;
  logic        fs_a, fs_b, vs_a, vs_b;
  logic [9:0]  tr_a, tg_a, tb_a, tr_b, tg_b, tb_b;

  int n_cmp = 0;
  int n_err = 0;

  dvi_stream_tx #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(8), .PIX_LAT(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_a), .solid_i(solid_a),
    .red_i(red_a), .green_i(grn_a), .blue_i(blu_a),
    .x_o(x_a), .y_o(y_a), .frame_start_o(fs_a),
    .tmds_blue_o(tb_a), .tmds_green_o(tg_a), .tmds_red_o(tr_a), .vsync_o(vs_a)
  );

  dvi_stream_tx #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(8), .PIX_LAT(3)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_b), .solid_i(solid_b),
    .red_i(red_b), .green_i(grn_b), .blue_i(blu_b),
    .x_o(x_b), .y_o(y_b), .frame_start_o(fs_b),
    .tmds_blue_o(tb_b), .tmds_green_o(tg_b), .tmds_red_o(tr_b), .vsync_o(vs_b)
  );

  // Red for dut_b is the column index that was on x_o three cycles earlier
  assign red_b = 8'((int'(x_b) + HT - 3) % HT);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tmds_dec(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic logic [31:0] rgb_a();
    return {8'h00, tmds_dec(tr_a), tmds_dec(tg_a), tmds_dec(tb_a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(int'(x_a) == x && int'(y_a) == y) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_err++;
      $error("FAIL wait_xy: position %0d,%0d not reached, observed %0d,%0d", x, y, x_a, y_a);
    end
  endtask

  task automatic lat(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int fs_cnt, max_x, max_y;
    rst_n   = 1'b0;
    mode_a  = 2'd1;
    solid_a = 24'h000000;
    red_a   = 8'h5A;
    grn_a   = 8'hC3;
    blu_a   = 8'h0F;
    mode_b  = 2'd3;
    solid_b = 24'hFFFFFF;
    grn_b   = 8'hA5;
    blu_b   = 8'h3C;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_x", 32'(x_a), 32'd0);
    check("rst_y", 32'(y_a), 32'd0);
    check("rst_fs", 32'(fs_a), 32'd0);
    check("rst_red", 32'(tr_a), 32'(C00));
    check("rst_blue", 32'(tb_a), 32'(C00));
    check("rst_vs_a", 32'(vs_a), 32'd1);
    check("rst_vs_b", 32'(vs_b), 32'd0);

    // Raster counting over one full frame
    rst_n = 1'b1;
    #1;
    check("fs_first", 32'(fs_a), 32'd1);
    fs_cnt = 0;
    max_x  = 0;
    max_y  = 0;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      fs_cnt += int'(fs_a);
      if (int'(x_a) > max_x) max_x = int'(x_a);
      if (int'(y_a) > max_y) max_y = int'(y_a);
      if (k == 24) check("y_inc", 32'(y_a), 32'd1);
    end
    check("fs_per_frame", 32'(fs_cnt), 32'd1);
    check("x_max", 32'(max_x), 32'd23);
    check("y_max", 32'(max_y), 32'd7);
    check("wrap_xy", 32'({y_a, x_a}), 32'd0);
    check("fs_wrap", 32'(fs_a), 32'd1);

    // Colour bars (frame 1), bar width 2
    wait_xy(0, 0);  lat(2); check("bar_white", rgb_a(), 32'hFFFFFF);
    wait_xy(3, 0);  lat(2); check("bar_yellow", rgb_a(), 32'hFFFF00);
    wait_xy(12, 0); lat(2); check("bar_blue", rgb_a(), 32'h0000FF);
    wait_xy(14, 0); lat(2); check("bar_black", rgb_a(), 32'h000000);
    wait_xy(16, 0); lat(2);
    check("blank_red", 32'(tr_a), 32'(C00));
    check("blank_green", 32'(tg_a), 32'(C00));
    check("blank_blue", 32'(tb_a), 32'(C11));
    wait_xy(18, 0); lat(2); check("hsync_first", 32'(tb_a), 32'(C10));
    wait_xy(20, 0); lat(2); check("hsync_last", 32'(tb_a), 32'(C10));
    wait_xy(22, 0); lat(2); check("hsync_end", 32'(tb_a), 32'(C11));

    // External pixels through a 3-cycle latency, mode 3 treated as external
    wait_xy(0, 1);  lat(4); check("ext_col0", 32'(tmds_dec(tr_b)), 32'd0);
    wait_xy(15, 1); lat(4); check("ext_col15", 32'(tmds_dec(tr_b)), 32'd15);
    wait_xy(19, 1); lat(4); check("b_hsync_pos", 32'(tb_b), 32'(C01));
    wait_xy(5, 2);  lat(4); check("ext_gb", 32'({tmds_dec(tg_b), tmds_dec(tb_b)}), 32'hA53C);
    wait_xy(16, 2); lat(4); check("b_blank_red", 32'(tr_b), 32'(C00));

    // Vertical sync timing
    wait_xy(23, 4); lat(2); check("vs_before", 32'(vs_a), 32'd1);
    wait_xy(0, 5);  lat(2);
    check("vs_start", 32'(vs_a), 32'd0);
    check("vs_blue", 32'(tb_a), 32'(C01));
    wait_xy(18, 5); lat(2); check("hvs_blue", 32'(tb_a), 32'(C00));
    wait_xy(1, 6);  lat(4); check("b_vs_pos", 32'(vs_b), 32'd1);
    wait_xy(23, 6); lat(2); check("vs_last", 32'(vs_a), 32'd0);
    wait_xy(0, 7);  lat(2); check("vs_after", 32'(vs_a), 32'd1);

    // Solid black (frame 2): DC balance alternates the two zero symbols
    mode_a  = 2'd2;
    solid_a = 24'h000000;
    wait_xy(0, 0); lat(2);
    for (int i = 0; i < 4; i++) begin
      check("solid0_sym", 32'(tr_a), 32'((i % 2 == 0) ? ZERO_A : ZERO_B));
      @(negedge clk);
    end
    mode_a = 2'd1;
    wait_xy(0, 1); lat(2); check("disp_reset", 32'(tg_a), 32'(ZERO_A));
    wait_xy(2, 1); lat(2); check("mode_hold", rgb_a(), 32'h000000);
    mode_a  = 2'd2;
    solid_a = 24'h123456;
    wait_xy(6, 2); lat(2); check("solid_hold", rgb_a(), 32'h000000);
    wait_xy(0, 0); lat(2); check("solid_new", rgb_a(), 32'h123456);

    // Mid-line reset
    wait_xy(10, 1);
    rst_n  = 1'b0;
    mode_a = 2'd0;
    #1;
    check("mid_rst_xy", 32'({y_a, x_a}), 32'd0);
    check("mid_rst_fs", 32'(fs_a), 32'd0);
    check("mid_rst_red", 32'(tr_a), 32'(C00));
    check("mid_rst_blue", 32'(tb_a), 32'(C00));
    check("mid_rst_vs", 32'(vs_a), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_xy", 32'({y_a, x_a}), 32'd0);
    wait_xy(3, 0); lat(2); check("ext_after_rst", rgb_a(), 32'h5AC30F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
